// File: rtl/reaction_responder.sv
// Automatic player for the reaction timer: presses start, watches led, presses stop.
// Ports: ms_clk/reset, go/mode/delay_ms/led in; btn_start/btn_stop/busy/done/status/measured out.
module reaction_responder #(
  parameter int DW         = 16,
  parameter int PRESS_MS   = 20,
  parameter int TIMEOUT_MS = 12000
) (
  input  logic          ms_clk,
  input  logic          reset,
  input  logic          go,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] delay_ms,
  input  logic          led,
  output logic          btn_start,
  output logic          btn_stop,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic [DW-1:0] measured
);

  localparam int TW = $clog2(TIMEOUT_MS + 1);

  localparam logic [DW-1:0] ONE_D      = DW'(1);
  localparam logic [TW-1:0] ONE_T      = TW'(1);
  localparam logic [DW-1:0] PRESS_LAST = DW'(PRESS_MS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_MS - 1);

  localparam logic [1:0] M_NORMAL = 2'd0;
  localparam logic [1:0] M_CHEAT  = 2'd1;
  localparam logic [1:0] M_NOPRS  = 2'd2;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_CHEAT   = 2'd1;
  localparam logic [1:0] ST_NOPRESS = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_START,
    S_WAIT_LED,
    S_DELAY,
    S_CHEAT_DLY,
    S_PRESS_STOP,
    S_WAIT_FALL,
    S_FINISH
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    mode_q, mode_nxt;
  logic [DW-1:0] dly_q, dly_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [1:0]    status_nxt;
  logic [DW-1:0] measured_nxt;

  always_ff @(posedge ms_clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      dly_q     <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      btn_start <= 1'b0;
      btn_stop  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= '0;
      measured  <= '0;
    end else begin
      state     <= state_nxt;
      mode_q    <= mode_nxt;
      dly_q     <= dly_nxt;
      cnt       <= cnt_nxt;
      tcnt      <= tcnt_nxt;
      // Outputs are registered copies of the next state
      btn_start <= (state_nxt == S_PRESS_START);
      btn_stop  <= (state_nxt == S_PRESS_STOP);
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_FINISH);
      status    <= status_nxt;
      measured  <= measured_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mode_nxt     = mode_q;
    dly_nxt      = dly_q;
    status_nxt   = status;
    measured_nxt = measured;
    // Saturating increments
    cnt_nxt      = (&cnt) ? cnt : cnt + ONE_D;
    tcnt_nxt     = (&tcnt) ? tcnt : tcnt + ONE_T;

    unique case (state)
      S_IDLE: begin
        if (go) begin
          state_nxt    = S_PRESS_START;
          mode_nxt     = (mode == 2'd3) ? M_NORMAL : mode;
          dly_nxt      = (delay_ms == '0) ? ONE_D : delay_ms;
          status_nxt   = ST_OK;
          measured_nxt = '0;
        end
      end
      S_PRESS_START: begin
        if (cnt == PRESS_LAST)
          state_nxt = (mode_q == M_CHEAT) ? S_CHEAT_DLY
                                          : S_WAIT_LED;
      end
      S_WAIT_LED: begin
        if (led) begin
          state_nxt = (mode_q == M_NOPRS) ? S_WAIT_FALL
                                          : S_DELAY;
        end else if (tcnt == TMO_LAST) begin
          state_nxt    = S_FINISH;
          status_nxt   = ST_TIMEOUT;
          measured_nxt = '0;
        end
      end
      S_DELAY, S_CHEAT_DLY: begin
        // dly_q is never 0, so D-1 cannot wrap
        if (cnt == dly_q - ONE_D)
          state_nxt = S_PRESS_STOP;
      end
      S_PRESS_STOP: begin
        if (cnt == PRESS_LAST) begin
          state_nxt = S_FINISH;
          if (mode_q == M_CHEAT) begin
            status_nxt   = ST_CHEAT;
            measured_nxt = '0;
          end else begin
            status_nxt   = ST_OK;
            measured_nxt = dly_q;
          end
        end
      end
      S_WAIT_FALL: begin
        if (!led) begin
          state_nxt    = S_FINISH;
          status_nxt   = ST_NOPRESS;
          measured_nxt = '0;
        end else if (tcnt == TMO_LAST) begin
          state_nxt    = S_FINISH;
          status_nxt   = ST_TIMEOUT;
          measured_nxt = '0;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // Each state starts counting from zero
    if (state_nxt != state || state == S_IDLE) begin
      cnt_nxt  = '0;
      tcnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_reaction_responder.sv
// Directed bench for reaction_responder: normal, cheat, no-press,
// timeout, zero delay, async reset mid-press and go-while-busy.
module tb_reaction_responder;

  localparam int DW = 16;
  localparam int PM = 20;
  localparam int TO = 12000;

  logic          ms_clk = 1'b0;
  logic          reset  = 1'b1;
  logic          go     = 1'b0;
  logic [1:0]    mode   = 2'd0;
  logic [DW-1:0] delay_ms = '0;
  logic          led    = 1'b0;
  logic          btn_start, btn_stop, busy, done;
  logic [1:0]    status;
  logic [DW-1:0] measured;

  int vectors = 0;
  int miscompares = 0;
  int both_cycles = 0;
  int stop_cycles = 0;
  int snap;

  reaction_responder #(
    .DW(DW), .PRESS_MS(PM), .TIMEOUT_MS(TO)
  ) dut (
    .ms_clk   (ms_clk),
    .reset    (reset),
    .go       (go),
    .mode     (mode),
    .delay_ms (delay_ms),
    .led      (led),
    .btn_start(btn_start),
    .btn_stop (btn_stop),
    .busy     (busy),
    .done     (done),
    .status   (status),
    .measured (measured)
  );

  always #5 ms_clk = ~ms_clk;

  always @(negedge ms_clk) begin
    if (btn_start && btn_stop) both_cycles++;
    if (btn_stop) stop_cycles++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ms_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [1:0] m, input int d);
    mode = m;
    delay_ms = DW'(d);
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".start"}, 32'(btn_start), 0);
    chk({tag, ".stop"}, 32'(btn_stop), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".status"}, 32'(status), 0);
    chk({tag, ".meas"}, 32'(measured), 0);
  endtask

  initial begin
    // Reset
    tick(2);
    chk_idle("rst");
    reset = 1'b0;
    tick(2);
    chk("rst.busy_after", 32'(busy), 0);

    // Normal trial: go at G, led sampled high first at E0=G+3001
    snap = both_cycles;
    start(2'd0, 250);
    chk("nrm.start_g", 32'(btn_start), 1);
    chk("nrm.busy_g", 32'(busy), 1);
    tick(19);
    chk("nrm.start_g19", 32'(btn_start), 1);
    tick();
    chk("nrm.start_g20", 32'(btn_start), 0);
    tick(2980);
    led = 1'b1;
    chk("nrm.stop_pre", 32'(btn_stop), 0);
    tick();
    tick(249);
    chk("nrm.stop_e249", 32'(btn_stop), 0);
    tick();
    chk("nrm.stop_e250", 32'(btn_stop), 1);
    tick(19);
    chk("nrm.stop_e269", 32'(btn_stop), 1);
    chk("nrm.done_e269", 32'(done), 0);
    tick();
    chk("nrm.stop_e270", 32'(btn_stop), 0);
    chk("nrm.done", 32'(done), 1);
    chk("nrm.busy_done", 32'(busy), 1);
    chk("nrm.status", 32'(status), 0);
    chk("nrm.meas", 32'(measured), 250);
    // go on the done edge is ignored
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("nrm.done_off", 32'(done), 0);
    chk("nrm.busy_off", 32'(busy), 0);
    chk("nrm.meas_hold", 32'(measured), 250);
    tick();
    chk("nrm.go_on_done", 32'(busy), 0);
    chk("nrm.excl", 32'(both_cycles - snap), 0);
    led = 1'b0;
    tick(3);

    // Cheat trial: stop rises 5 cycles after start falls
    snap = both_cycles;
    start(2'd1, 5);
    tick(20);
    chk("cht.start_off", 32'(btn_start), 0);
    chk("cht.stop_g20", 32'(btn_stop), 0);
    tick(4);
    chk("cht.stop_g24", 32'(btn_stop), 0);
    tick();
    chk("cht.stop_g25", 32'(btn_stop), 1);
    tick(20);
    chk("cht.done", 32'(done), 1);
    chk("cht.stop_off", 32'(btn_stop), 0);
    chk("cht.status", 32'(status), 1);
    chk("cht.meas", 32'(measured), 0);
    chk("cht.excl", 32'(both_cycles - snap), 0);
    tick(3);

    // No-press: led high 1000 cycles then low
    snap = stop_cycles;
    start(2'd2, 10);
    tick(20);
    led = 1'b1;
    tick(1000);
    led = 1'b0;
    chk("np.done_pre", 32'(done), 0);
    chk("np.busy_pre", 32'(busy), 1);
    tick();
    chk("np.done", 32'(done), 1);
    chk("np.status", 32'(status), 2);
    chk("np.meas", 32'(measured), 0);
    chk("np.no_stop", 32'(stop_cycles - snap), 0);
    tick(3);

    // Timeout: led never rises; WAIT_LED entered at G+20
    start(2'd0, 100);
    tick(20);
    tick(TO - 1);
    chk("to.done_pre", 32'(done), 0);
    chk("to.busy_pre", 32'(busy), 1);
    tick();
    chk("to.done", 32'(done), 1);
    chk("to.status", 32'(status), 3);
    chk("to.meas", 32'(measured), 0);
    tick(3);

    // Zero delay, led already high: E0=G+21, stop at G+22
    led = 1'b1;
    start(2'd0, 0);
    tick(21);
    chk("z.stop_e0", 32'(btn_stop), 0);
    tick();
    chk("z.stop_e1", 32'(btn_stop), 1);
    tick(20);
    chk("z.done", 32'(done), 1);
    chk("z.status", 32'(status), 0);
    chk("z.meas", 32'(measured), 1);
    tick(3);

    // Reset while btn_stop is high (stop rises at G+24)
    start(2'd0, 3);
    tick(25);
    chk("rm.stop_hi", 32'(btn_stop), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("rm.async");
    tick();
    reset = 1'b0;
    tick();
    chk_idle("rm.after");

    // Next go accepted; go pulses while busy are ignored
    start(2'd0, 2);
    chk("bz.start", 32'(btn_start), 1);
    tick(5);
    mode = 2'd1;
    delay_ms = DW'(50);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(30);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(5);
    chk("bz.done_pre", 32'(done), 0);
    tick();
    chk("bz.done", 32'(done), 1);
    chk("bz.status", 32'(status), 0);
    chk("bz.meas", 32'(measured), 2);
    tick();
    chk("bz.idle", 32'(busy), 0);
    led = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
